// File: rtl/sal_bank_ctrl.sv
// sal_bank_ctrl -- per-bank command sequencer (open-page policy).
//
// Turns scheduler read/write requests into ACT/RD/WR/PRE commands for one
// bank. It tracks whether a row is open and which row it is, and it gates
// each command on the timing windows tRCD, tRAS, tRTP, tWR-to-PRE and tRP.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   req_valid_i/req_wr_i/    scheduler request (held stable until consumed)
//   req_row_i
//   req_ready_o              pulses when the request's RD/WR is issued
//   cmd_valid_o/cmd_o/       command offered to the arbiter
//   cmd_row_o                (0=ACT 1=RD 2=WR 3=PRE)
//   cmd_ready_i              arbiter grant; issue = cmd_valid_o & cmd_ready_i
//   bank_open_o/open_row_o   registered bank state

// One timing window. The counter is loaded with T-1 on the issue cycle, then
// counts down and saturates at zero. o_zero is taken from the register, so a
// dependent command issued on cycle c is first allowed on cycle c+T.
module sal_bank_ctr #(
  parameter int W    = 4,
  parameter int LOAD = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  output logic o_zero
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_cnt <= '0;
    else if (i_load)         r_cnt <= W'(LOAD);
    else if (r_cnt != '0)    r_cnt <= r_cnt - W'(1);
  end

  assign o_zero = (r_cnt == '0);
endmodule

module sal_bank_ctrl #(
  parameter int ROW_WIDTH  = 16,
  parameter int CNTR_WIDTH = 4,
  parameter int T_RCD      = 5,
  parameter int T_RAS      = 12,
  parameter int T_RTP      = 3,
  parameter int T_WTP      = 10,
  parameter int T_RP       = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid_i,
  input  logic                 req_wr_i,
  input  logic [ROW_WIDTH-1:0] req_row_i,
  output logic                 req_ready_o,
  output logic                 cmd_valid_o,
  output logic [1:0]           cmd_o,
  output logic [ROW_WIDTH-1:0] cmd_row_o,
  input  logic                 cmd_ready_i,
  output logic                 bank_open_o,
  output logic [ROW_WIDTH-1:0] open_row_o
);
  localparam logic [1:0] CMD_ACT = 2'd0;
  localparam logic [1:0] CMD_RD  = 2'd1;
  localparam logic [1:0] CMD_WR  = 2'd2;
  localparam logic [1:0] CMD_PRE = 2'd3;

  typedef enum logic {ST_CLOSED = 1'b0, ST_OPEN = 1'b1} state_e;

  state_e               r_state, w_state_nxt;
  logic [ROW_WIDTH-1:0] r_open_row, w_open_row_nxt;

  logic                 w_cmd_valid;
  logic [1:0]           w_cmd;
  logic [ROW_WIDTH-1:0] w_cmd_row;
  logic                 w_issue;
  logic                 w_rcd_zero, w_ras_zero, w_rtp_zero, w_wtp_zero, w_rp_zero;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_CLOSED;
      r_open_row <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_open_row <= w_open_row_nxt;
    end
  end

  // Command selection and next state. Eligibility only depends on registered
  // state/counters plus the held request, and counters only move toward zero,
  // so an offered command stays offered until granted.
  always_comb begin
    w_cmd_valid    = 1'b0;
    w_cmd          = CMD_ACT;
    w_cmd_row      = r_open_row;
    w_state_nxt    = r_state;
    w_open_row_nxt = r_open_row;

    if (req_valid_i) begin
      case (r_state)
        ST_CLOSED: begin
          if (w_rp_zero) begin
            w_cmd_valid = 1'b1;
            w_cmd       = CMD_ACT;
            w_cmd_row   = req_row_i;
          end
        end
        ST_OPEN: begin
          if (req_row_i == r_open_row) begin
            if (w_rcd_zero) begin
              w_cmd_valid = 1'b1;
              w_cmd       = req_wr_i ? CMD_WR : CMD_RD;
            end
          end else if (w_ras_zero && w_rtp_zero && w_wtp_zero) begin
            w_cmd_valid = 1'b1;
            w_cmd       = CMD_PRE;
          end
        end
        default: ;
      endcase
    end

    w_issue = w_cmd_valid && cmd_ready_i;

    if (w_issue && w_cmd == CMD_ACT) begin
      w_state_nxt    = ST_OPEN;
      w_open_row_nxt = req_row_i;
    end else if (w_issue && w_cmd == CMD_PRE) begin
      w_state_nxt    = ST_CLOSED;
    end
  end

  // Timing windows, each measured from the issue cycle of its command
  sal_bank_ctr #(.W(CNTR_WIDTH), .LOAD(T_RCD-1)) u_rcd (
    .clk(clk), .rst_n(rst_n), .i_load(w_issue && w_cmd == CMD_ACT), .o_zero(w_rcd_zero));
  sal_bank_ctr #(.W(CNTR_WIDTH), .LOAD(T_RAS-1)) u_ras (
    .clk(clk), .rst_n(rst_n), .i_load(w_issue && w_cmd == CMD_ACT), .o_zero(w_ras_zero));
  sal_bank_ctr #(.W(CNTR_WIDTH), .LOAD(T_RTP-1)) u_rtp (
    .clk(clk), .rst_n(rst_n), .i_load(w_issue && w_cmd == CMD_RD),  .o_zero(w_rtp_zero));
  sal_bank_ctr #(.W(CNTR_WIDTH), .LOAD(T_WTP-1)) u_wtp (
    .clk(clk), .rst_n(rst_n), .i_load(w_issue && w_cmd == CMD_WR),  .o_zero(w_wtp_zero));
  sal_bank_ctr #(.W(CNTR_WIDTH), .LOAD(T_RP-1))  u_rp  (
    .clk(clk), .rst_n(rst_n), .i_load(w_issue && w_cmd == CMD_PRE), .o_zero(w_rp_zero));

  // In reset the state reads CLOSED with rp at zero, which would offer an ACT
  // combinationally; rst_n masks the handshake outputs so nothing escapes.
  assign cmd_valid_o = w_cmd_valid && rst_n;
  assign cmd_o       = w_cmd;
  assign cmd_row_o   = w_cmd_row;
  assign req_ready_o = w_issue && rst_n && (w_cmd == CMD_RD || w_cmd == CMD_WR);
  assign bank_open_o = (r_state == ST_OPEN);
  assign open_row_o  = r_open_row;
endmodule

// File: tb/tb_sal_bank_ctrl.sv
// Directed bench for sal_bank_ctrl: a default-timing instance and an
// all-T=1 instance share stimulus; sel picks which one is observed.
module tb_sal_bank_ctrl;
  localparam int RW = 16;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          req_valid = 1'b0, req_wr = 1'b0, cmd_ready = 1'b1;
  logic [RW-1:0] req_row = '0;
  logic          sel = 1'b0;

  logic          d_req_ready, d_cmd_valid, d_bank_open;
  logic [1:0]    d_cmd;
  logic [RW-1:0] d_cmd_row, d_open_row;
  logic          s_req_ready, s_cmd_valid, s_bank_open;
  logic [1:0]    s_cmd;
  logic [RW-1:0] s_cmd_row, s_open_row;

  logic          m_req_ready, m_valid, m_bank_open;
  logic [1:0]    m_cmd;
  logic [RW-1:0] m_row, m_open_row;

  int cyc = 0, t0 = 0, checks = 0, failures = 0;

  sal_bank_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_wr_i(req_wr),
    .req_row_i(req_row), .req_ready_o(d_req_ready), .cmd_valid_o(d_cmd_valid),
    .cmd_o(d_cmd), .cmd_row_o(d_cmd_row), .cmd_ready_i(cmd_ready),
    .bank_open_o(d_bank_open), .open_row_o(d_open_row));

  sal_bank_ctrl #(.T_RCD(1), .T_RAS(1), .T_RTP(1), .T_WTP(1), .T_RP(1)) u_fast (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_wr_i(req_wr),
    .req_row_i(req_row), .req_ready_o(s_req_ready), .cmd_valid_o(s_cmd_valid),
    .cmd_o(s_cmd), .cmd_row_o(s_cmd_row), .cmd_ready_i(cmd_ready),
    .bank_open_o(s_bank_open), .open_row_o(s_open_row));

  assign m_req_ready = sel ? s_req_ready : d_req_ready;
  assign m_valid     = sel ? s_cmd_valid : d_cmd_valid;
  assign m_cmd       = sel ? s_cmd       : d_cmd;
  assign m_row       = sel ? s_cmd_row   : d_cmd_row;
  assign m_bank_open = sel ? s_bank_open : d_bank_open;
  assign m_open_row  = sel ? s_open_row  : d_open_row;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for the next issued command, checks it and its cycle
  // relative to t0, then steps past the issuing edge.
  task automatic wait_cmd(input string tag, input logic [1:0] c,
                          input logic [RW-1:0] row, input int at);
    int n = 0;
    @(negedge clk);
    while (!(m_valid && cmd_ready) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_cmd"}, 32'(m_cmd), 32'(c));
    chk({tag, "_row"}, 32'(m_row), 32'(row));
    chk({tag, "_cyc"}, cyc - t0, at);
    chk({tag, "_rdy"}, 32'(m_req_ready), 32'(c == 2'd1 || c == 2'd2));
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    t0 = cyc;
  endtask

  initial begin
    int n;

    // T2: idle grants ignored, then ACT@0, RD@5
    do_reset();
    req_valid = 1'b0; cmd_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t2_idle_open", 32'(m_bank_open), 0);
    chk("t2_idle_valid", 32'(m_valid), 0);
    t0 = cyc;
    req_valid = 1'b1; req_wr = 1'b0; req_row = 16'h0012;
    wait_cmd("t2_act", 2'd0, 16'h0012, 0);
    chk("t2_open", 32'(m_bank_open), 1);
    chk("t2_open_row", 32'(m_open_row), 32'h12);
    wait_cmd("t2_rd", 2'd1, 16'h0012, 5);
    req_valid = 1'b0;

    // T3: row miss after read -> tRAS binds
    do_reset();
    req_valid = 1'b1; req_wr = 1'b0; req_row = 16'h0012;
    wait_cmd("t3_act", 2'd0, 16'h0012, 0);
    wait_cmd("t3_rd", 2'd1, 16'h0012, 5);
    req_row = 16'h0034;
    wait_cmd("t3_pre", 2'd3, 16'h0012, 12);
    chk("t3_closed", 32'(m_bank_open), 0);
    wait_cmd("t3_act2", 2'd0, 16'h0034, 17);
    wait_cmd("t3_rd2", 2'd1, 16'h0034, 22);
    req_valid = 1'b0;

    // T4: row miss after write -> tWTP binds
    do_reset();
    req_valid = 1'b1; req_wr = 1'b1; req_row = 16'h0012;
    wait_cmd("t4_act", 2'd0, 16'h0012, 0);
    wait_cmd("t4_wr", 2'd2, 16'h0012, 5);
    req_wr = 1'b0; req_row = 16'h0034;
    wait_cmd("t4_pre", 2'd3, 16'h0012, 15);
    wait_cmd("t4_act2", 2'd0, 16'h0034, 20);
    req_valid = 1'b0;

    // T5: stalled ACT holds stable; timing counts from the issue cycle
    do_reset();
    req_valid = 1'b1; req_wr = 1'b0; req_row = 16'h0056; cmd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_stall_valid", 32'(m_valid), 1);
      chk("t5_stall_cmd", 32'(m_cmd), 0);
      chk("t5_stall_row", 32'(m_row), 32'h56);
      @(posedge clk); #1;
    end
    chk("t5_stall_closed", 32'(m_bank_open), 0);
    cmd_ready = 1'b1;
    wait_cmd("t5_act", 2'd0, 16'h0056, 3);
    wait_cmd("t5_rd", 2'd1, 16'h0056, 8);
    req_valid = 1'b0;

    // T1: reset while a PRE is offered, then immediate ACT after release
    do_reset();
    req_valid = 1'b1; req_wr = 1'b0; req_row = 16'h0012;
    wait_cmd("t1_act", 2'd0, 16'h0012, 0);
    wait_cmd("t1_rd", 2'd1, 16'h0012, 5);
    req_row = 16'h0034; cmd_ready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!m_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("t1_pre_offer", 32'(m_cmd), 3);
    chk("t1_pre_cyc", cyc - t0, 12);
    #1 rst_n = 1'b0;
    #1;
    chk("t1_rst_valid", 32'(m_valid), 0);
    chk("t1_rst_open", 32'(m_bank_open), 0);
    chk("t1_rst_ready", 32'(m_req_ready), 0);
    req_row = 16'h0012;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; cmd_ready = 1'b1;
    t0 = cyc;
    wait_cmd("t1_act2", 2'd0, 16'h0012, 0);
    req_valid = 1'b0;

    // T6: all T=1 -> back-to-back commands
    sel = 1'b1;
    do_reset();
    req_valid = 1'b1; req_wr = 1'b0; req_row = 16'h0012;
    wait_cmd("t6_act", 2'd0, 16'h0012, 0);
    wait_cmd("t6_rd", 2'd1, 16'h0012, 1);
    req_row = 16'h0034;
    wait_cmd("t6_pre", 2'd3, 16'h0012, 2);
    wait_cmd("t6_act2", 2'd0, 16'h0034, 3);
    req_wr = 1'b1;
    wait_cmd("t6_wr", 2'd2, 16'h0034, 4);
    req_valid = 1'b0;
    sel = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
